// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, logical/arithmetic shifts and rotates,
// with a saturating count of valid bits not yet shifted out. State updates on falling clk.
module univ_shift_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_b,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         sin,
  output logic [WIDTH-1:0]             q,
  output logic                         sout,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         empty
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             shifting;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      sout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      sout_q <= sout_d;
    end
  end

  // Synchronous clear beats enable, which beats the mode decode.
  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    sout_d   = sout_q;
    shifting = 1'b0;
    if (!clear_b) begin
      q_d    = '0;
      cnt_d  = '0;
      sout_d = 1'b0;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = CW'(WIDTH);
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], sin};
          sout_d   = q_q[WIDTH-1];
          shifting = 1'b1;
        end
        MODE_SHR: begin
          q_d      = {sin, q_q[WIDTH-1:1]};
          sout_d   = q_q[0];
          shifting = 1'b1;
        end
        MODE_ROL: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d   = q_q[WIDTH-1];
          shifting = 1'b1;
        end
        MODE_ROR: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          sout_d   = q_q[0];
          shifting = 1'b1;
        end
        MODE_ASR: begin
          q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          sout_d   = q_q[0];
          shifting = 1'b1;
        end
        default: begin
          q_d = q_q;
        end
      endcase
      // The count saturates at zero while the data path keeps moving.
      if (shifting && (cnt_q != '0)) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  assign q     = q_q;
  assign cnt   = cnt_q;
  assign sout  = sout_q;
  assign empty = (cnt_q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed scenarios followed by random
// operations, compared against an integer-arithmetic reference model.
module tb_univ_shift_reg;

  logic       clk;
  logic       reset;
  logic       clear_b;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin;
  logic [7:0] q;
  logic       sout;
  logic [3:0] cnt;
  logic       empty;

  int total = 0;
  int bad   = 0;

  int mq;
  int mcnt;
  int msout;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk     (clk),
    .reset   (reset),
    .clear_b (clear_b),
    .en      (en),
    .mode    (mode),
    .d       (d),
    .sin     (sin),
    .q       (q),
    .sout    (sout),
    .cnt     (cnt),
    .empty   (empty)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic modelReset();
    mq = 0; mcnt = 0; msout = 0;
  endtask

  // Reference behaviour expressed as arithmetic on the register value.
  task automatic modelStep(input int cb, input int e, input int m, input int dd, input int s);
    int shifted;
    shifted = 0;
    if (cb == 0) begin
      mq = 0; mcnt = 0; msout = 0;
    end else if (e != 0) begin
      case (m)
        1: begin mq = dd; mcnt = 8; end
        2: begin msout = mq / 128; mq = (mq * 2 + s) % 256; shifted = 1; end
        3: begin msout = mq % 2; mq = mq / 2 + s * 128; shifted = 1; end
        4: begin msout = mq / 128; mq = (mq * 2) % 256 + mq / 128; shifted = 1; end
        5: begin msout = mq % 2; mq = mq / 2 + (mq % 2) * 128; shifted = 1; end
        6: begin msout = mq % 2; mq = mq / 2 + ((mq >= 128) ? 128 : 0); shifted = 1; end
        default: ;
      endcase
      if (shifted != 0 && mcnt > 0) mcnt = mcnt - 1;
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s actual=%0h required=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".q"}, int'(q), mq);
    checkValue({tag, ".cnt"}, int'(cnt), mcnt);
    checkValue({tag, ".sout"}, int'(sout), msout);
    checkValue({tag, ".empty"}, int'(empty), (mcnt == 0) ? 1 : 0);
  endtask

  // Drive inputs just after a falling edge, let the next falling edge act, then compare.
  task automatic applyStimulus(input string tag, input logic cb, input logic e,
                               input logic [2:0] m, input logic [7:0] dd, input logic s);
    clear_b = cb; en = e; mode = m; d = dd; sin = s;
    @(negedge clk);
    modelStep(int'(cb), int'(e), int'(m), int'(dd), int'(s));
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset = 1'b1; clear_b = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00; sin = 1'b0;
    modelReset();
    #2;
    checkOutput("reset");
    reset = 1'b0;
    #1;

    // Load 0xA5 and shift it completely out to the left.
    applyStimulus("a5_load", 1, 1, 3'b001, 8'hA5, 0);
    for (int i = 0; i < 8; i++) applyStimulus("a5_shl", 1, 1, 3'b010, 8'h00, 0);
    checkValue("a5_final_q", int'(q), 0);
    checkValue("a5_final_empty", int'(empty), 1);
    applyStimulus("shl_sat", 1, 1, 3'b010, 8'h00, 1);

    // Rotations.
    applyStimulus("81_load", 1, 1, 3'b001, 8'h81, 0);
    applyStimulus("81_ror", 1, 1, 3'b101, 8'h00, 0);
    checkValue("81_ror_q", int'(q), 'hC0);
    checkValue("81_ror_cnt", int'(cnt), 7);
    applyStimulus("81_rol", 1, 1, 3'b100, 8'h00, 0);
    checkValue("81_rol_q", int'(q), 'h81);

    // Arithmetic shift right.
    applyStimulus("80_load", 1, 1, 3'b001, 8'h80, 0);
    applyStimulus("80_asr1", 1, 1, 3'b110, 8'h00, 1);
    applyStimulus("80_asr2", 1, 1, 3'b110, 8'h00, 1);
    checkValue("80_asr_q", int'(q), 'hE0);

    // Clear wins over a disabled enable.
    applyStimulus("5a_load", 1, 1, 3'b001, 8'h5A, 0);
    applyStimulus("5a_shr", 1, 1, 3'b011, 8'h00, 1);
    applyStimulus("clear", 0, 0, 3'b010, 8'h00, 1);
    checkValue("clear_q", int'(q), 0);

    // Asynchronous reset between edges.
    applyStimulus("ff_load", 1, 1, 3'b001, 8'hFF, 0);
    applyStimulus("ff_shr1", 1, 1, 3'b011, 8'h00, 0);
    applyStimulus("ff_shr2", 1, 1, 3'b011, 8'h00, 0);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("async_reset");
    reset = 1'b0;
    #1;
    applyStimulus("3c_load", 1, 1, 3'b001, 8'h3C, 0);
    checkValue("3c_cnt", int'(cnt), 8);

    // Disabled load and reserved mode both hold.
    applyStimulus("0f_noen", 1, 0, 3'b001, 8'h0F, 0);
    applyStimulus("rsvd", 1, 1, 3'b111, 8'h0F, 1);
    applyStimulus("hold", 1, 1, 3'b000, 8'h0F, 1);

    // Random operations with occasional clears, disables and async resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        #($urandom_range(1, 6));
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("rnd_reset");
        reset = 1'b0;
        @(negedge clk);
        #1;
        modelStep(int'(clear_b), int'(en), int'(mode), int'(d), int'(sin));
        checkOutput("rnd_after_reset");
      end else begin
        applyStimulus("rnd", ($urandom_range(0, 15) != 0), ($urandom_range(0, 7) != 0),
                      3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
